state_event_sequencer: RTL and testbench
========================================

# state_event_sequencer

Upstream driver for the stat register bank (`Registro_states`). Turns raw button levels and a periodic decay timer into a serialized stream of single-cycle `UpState`/`DownState` pulses, each paired with a `state` address. Button presses raise a stat by one. The decay timer lowers the stats one at a time in round-robin order. Exactly one event is presented per issue slot, so the register bank never sees conflicting commands.

## Interface
- `BIT_ADDR`, 3: width of the `state` address; must match the register bank.
- `NUM_STATS`, 4: number of active stats, at addresses 0..NUM_STATS-1; must satisfy NUM_STATS ≤ 2**BIT_ADDR.
- `DECAY_PERIOD`, 50_000_000: clock cycles between decay events; must be ≥ 2.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_up`  in  NUM_STATS  asynchronous button levels; bit i requests +1 on stat i.
- `state`  out  BIT_ADDR  address of the current event; held stable outside ISSUE.
- `UpState`  out  1  one-cycle increment pulse.
- `DownState`  out  1  one-cycle decrement pulse.
- `busy`  out  1  high while the FSM is in ISSUE or GAP.
- `overrun`  out  1  sticky; a request was merged into an already-pending one.

## Operation
- **Input stage, per button bit:**
  - two-flop synchronizer, then an edge-detect flop.
  - A rising edge sets `pend_up[i]`.
- **Decay timer:**
  - counter runs 0..DECAY_PERIOD-1.
  - On wrap it sets `pend_dn[ptr]` and advances `ptr` (0..NUM_STATS-1, wraps to 0).
- **Overrun:** if a set event hits a pending bit that is already 1 and is not being cleared that cycle, the requests merge into one and `overrun` is set. Only reset clears `overrun`.
- **FSM states IDLE, ISSUE, GAP:**
  - IDLE: if any pending bit is set, latch the address and direction, clear that bit, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `UpState` or `DownState` high for exactly one cycle, then go to GAP.
  - GAP: one settle cycle so the bank's `stateValue` reflects the write, then go to IDLE.
- **Arbitration in IDLE:**
  - any `pend_up` beats any `pend_dn`.
  - Within a class, the lowest index wins.
- **Same-cycle set and clear of one bit:** set wins, so the bit stays pending and no overrun is flagged.
- **Pulse exclusivity:** `UpState` and `DownState` are never high together and are never high outside ISSUE.
- **Reset values:**
  - `state` = 0, `UpState` = 0, `DownState` = 0, `busy` = 0, `overrun` = 0.
  - Timer, `ptr`, all pending bits and all synchronizer/edge flops = 0.
- **Button held through reset:** it produces one up request after reset is released.
- **Reset mid-operation:** reset during ISSUE or GAP aborts the event with no further pulse, and all pending requests are discarded.

## Timing
- All outputs are registered.
- **Button latency:** `btn_up[i]` rising before edge k sets `pend_up[i]` at edge k+2. The FSM enters ISSUE at edge k+3, so the pulse is visible in cycle k+3.
- **Decay latency:** the timer wraps at edge t, which sets `pend_dn`. ISSUE is entered at edge t+1 if the FSM was idle.
- **Throughput:** at most one event per 3 cycles (ISSUE, GAP, IDLE).
- **Timer independence:** the decay timer is never stalled by FSM activity.

## Structure
- **Shared package `fsm_drivers_pkg`:**
  - FSM state enum {IDLE, ISSUE, GAP}.
  - Default constants for BIT_ADDR and NUM_STATS, shared with the register bank.
- **Sub-module `btn_sync_edge`:** one-bit two-flop synchronizer plus rising-edge detector with synchronous reset; instantiated NUM_STATS times.
- **Top level:** pending registers, decay timer, priority arbiter and FSM.

## Test plan
All scenarios use bench parameters DECAY_PERIOD=8, NUM_STATS=4.
- **Reset:** hold `rst` 3 cycles with `btn_up`=0 → all outputs 0. The first `DownState` appears with `state`=0 one cycle after the 8th cycle after release, and subsequent ones come every 8 cycles with `state`=1,2,3,0.
- **Single press:** raise `btn_up[2]` for 1 cycle with no decay pending → exactly one `UpState` pulse 3 cycles later with `state`=2, then `busy` held for 2 cycles.
- **Simultaneous requests:** raise `btn_up[3]` and `btn_up[1]` together in the same cycle as a decay wrap for ptr=0 → pulses in order Up@1, Up@3, Down@0, spaced 3 cycles apart.
- **Merge and overrun:** press `btn_up[0]` twice, 2 cycles apart, while the FSM is busy with another event → only one Up@0 pulse, and `overrun`=1 until reset.
- **Reset mid-event:** assert `rst` during ISSUE → the pulse drops the next cycle, pending requests are cleared, `state`=0, and no pulse follows.
- **Protocol check (continuous):** random `btn_up` toggling over 10k cycles → `UpState & DownState` is never 1, every pulse lasts exactly 1 cycle, and pulses are at least 3 cycles apart.

Source files
------------

// File: rtl/fsm_drivers_pkg.sv
// Shared types and default sizing for the stat-bank driver FSMs.
// The register bank uses the same constants, so both sides agree on address width.
package fsm_drivers_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } fsm_t;

  localparam int DEF_BIT_ADDR  = 3;
  localparam int DEF_NUM_STATS = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// One-bit two-flop synchronizer followed by a rising-edge detector.
// rise is high for one cycle per synchronized low-to-high transition of din.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s_p0, s_p1, s_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
      s_p2 <= 1'b0;
    end else begin
      s_p0 <= din;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign rise = s_p1 & ~s_p2;

endmodule

// File: rtl/state_event_sequencer.sv
// Serializes button increments and round-robin decay decrements into single-cycle
// UpState/DownState pulses with a matching state address, one event per 3 cycles.
module state_event_sequencer
  import fsm_drivers_pkg::*;
#(
  parameter int BIT_ADDR     = DEF_BIT_ADDR,
  parameter int NUM_STATS    = DEF_NUM_STATS,
  parameter int DECAY_PERIOD = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_STATS-1:0] btn_up,
  output logic [BIT_ADDR-1:0]  state,
  output logic                 UpState,
  output logic                 DownState,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TMR_W = $clog2(DECAY_PERIOD);
  localparam int PTR_W = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_PERIOD - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_STATS - 1);

  fsm_t                 fsm;
  logic [NUM_STATS-1:0] rise;
  logic [NUM_STATS-1:0] pend_up, pend_dn;
  logic [NUM_STATS-1:0] up_set, dn_set, up_clr, dn_clr, grant_mask;
  logic [TMR_W-1:0]     tmr;
  logic [PTR_W-1:0]     ptr;
  logic                 wrap, take, merge;
  logic                 grant_vld, grant_up;
  logic [BIT_ADDR-1:0]  grant_idx;

  function automatic logic [BIT_ADDR-1:0] lowest_idx(input logic [NUM_STATS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_STATS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = BIT_ADDR'(i);
    end
  endfunction

  // Input stage: per-button synchronizer and edge detector
  for (genvar g = 0; g < NUM_STATS; g++) begin : g_btn
    btn_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_up[g]),
      .rise (rise[g])
    );
  end

  // Decay timer free-runs regardless of FSM activity
  assign wrap = (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
      ptr <= '0;
    end else if (wrap) begin
      tmr <= '0;
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Arbiter: any increment beats any decrement, lowest index within a class
  always_comb begin
    grant_vld = (|pend_up) || (|pend_dn);
    grant_up  = |pend_up;
    grant_idx = grant_up ? lowest_idx(pend_up) : lowest_idx(pend_dn);
  end

  assign take       = (fsm == IDLE) && grant_vld;
  assign grant_mask = NUM_STATS'(1) << grant_idx;
  assign up_clr     = (take && grant_up)  ? grant_mask : '0;
  assign dn_clr     = (take && !grant_up) ? grant_mask : '0;
  assign up_set     = rise;
  assign dn_set     = wrap ? (NUM_STATS'(1) << ptr) : '0;

  // A set landing on a bit that stays pending collapses two requests into one
  assign merge = (|(up_set & pend_up & ~up_clr)) || (|(dn_set & pend_dn & ~dn_clr));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_up <= '0;
      pend_dn <= '0;
      overrun <= 1'b0;
    end else begin
      pend_up <= (pend_up & ~up_clr) | up_set;
      pend_dn <= (pend_dn & ~dn_clr) | dn_set;
      if (merge) overrun <= 1'b1;
    end
  end

  // Issue FSM: IDLE -> ISSUE (pulse) -> GAP (bank settles) -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= '0;
      UpState   <= 1'b0;
      DownState <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (grant_vld) begin
            fsm       <= ISSUE;
            state     <= grant_idx;
            UpState   <= grant_up;
            DownState <= !grant_up;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          fsm       <= GAP;
          UpState   <= 1'b0;
          DownState <= 1'b0;
          busy      <= 1'b1;
        end
        GAP: begin
          fsm  <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          fsm       <= IDLE;
          UpState   <= 1'b0;
          DownState <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_event_sequencer.sv
// Bench for state_event_sequencer: a cycle model predicts each pulse into a queue,
// a negedge monitor pops and compares; directed scenarios add fixed-timing checks.
module tb_state_event_sequencer;

  localparam int NS = 4;
  localparam int DP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_up;
  logic [2:0] state;
  logic       UpState, DownState, busy, overrun;

  state_event_sequencer #(
    .BIT_ADDR     (3),
    .NUM_STATS    (NS),
    .DECAY_PERIOD (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .state     (state),
    .UpState   (UpState),
    .DownState (DownState),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit up;
    int addr;
  } ev_t;

  ev_t exp_q[$];
  ev_t seen[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, evaluated at every rising edge
  logic [3:0] m_b1, m_b2, m_b3, m_pu, m_pd;
  int         m_tmr, m_ptr, m_fsm;
  bit         m_busy, m_ovr;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    logic [3:0] rise_v, dnset, upclr, dnclr;
    int         idx;
    bit         wrap;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_b1 = '0; m_b2 = '0; m_b3 = '0; m_pu = '0; m_pd = '0;
        m_tmr = 0; m_ptr = 0; m_fsm = 0; m_busy = 0; m_ovr = 0;
        exp_q.delete();
      end else begin
        rise_v = m_b2 & ~m_b3;
        wrap   = (m_tmr == DP - 1);
        dnset  = wrap ? (4'b0001 << m_ptr) : 4'b0000;
        upclr  = '0;
        dnclr  = '0;
        if (m_fsm == 0 && (m_pu != 0 || m_pd != 0)) begin
          if (m_pu != 0) begin
            idx = lowest(m_pu);
            upclr = 4'b0001 << idx;
            exp_q.push_back('{cyc, 1'b1, idx});
          end else begin
            idx = lowest(m_pd);
            dnclr = 4'b0001 << idx;
            exp_q.push_back('{cyc, 1'b0, idx});
          end
          m_fsm = 1; m_busy = 1;
        end else if (m_fsm == 1) begin
          m_fsm = 2; m_busy = 1;
        end else if (m_fsm == 2) begin
          m_fsm = 0; m_busy = 0;
        end
        if (((rise_v & m_pu & ~upclr) != 0) || ((dnset & m_pd & ~dnclr) != 0)) m_ovr = 1;
        m_pu = (m_pu & ~upclr) | rise_v;
        m_pd = (m_pd & ~dnclr) | dnset;
        m_b3 = m_b2; m_b2 = m_b1; m_b1 = btn_up;
        if (wrap) begin
          m_tmr = 0;
          m_ptr = (m_ptr + 1) % NS;
        end else begin
          m_tmr = m_tmr + 1;
        end
      end
    end
  end

  // Monitor: scoreboard pop plus protocol checks on every pulse
  initial begin
    int  last_pulse = -100;
    ev_t e;
    forever begin
      @(negedge clk);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      if (UpState || DownState) begin
        chk("pulse_excl", UpState & DownState, 0);
        chk("pulse_spacing", (cyc - last_pulse) >= 3, 1);
        last_pulse = cyc;
        seen.push_back('{cyc, UpState, int'(state)});
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_cycle", cyc, e.cyc);
          chk("sb_up", UpState, e.up);
          chk("sb_addr", state, e.addr);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missed_pulse", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    r = cyc;
    seen.delete();
  endtask

  function automatic int count_up(input int addr);
    int n = 0;
    foreach (seen[i]) if (seen[i].up && seen[i].addr == addr) n++;
    return n;
  endfunction

  function automatic int first_up(input int addr);
    foreach (seen[i]) if (seen[i].up && seen[i].addr == addr) return seen[i].cyc;
    return -1;
  endfunction

  initial begin
    int r;
    rst    = 1'b1;
    btn_up = '0;

    // Reset state, then four decays in round-robin order
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_up", UpState, 0);
    chk("rst_dn", DownState, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    r = cyc;
    seen.delete();
    tick(33);
    chk("decay_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen.size()) begin
        chk("decay_cycle", seen[i].cyc - r, 9 + 8 * i);
        chk("decay_dir", seen[i].up, 0);
        chk("decay_addr", seen[i].addr, i);
      end
    end

    // Single press of button 2
    seen.delete();
    btn_up = 4'b0100;
    tick(1);
    btn_up = 4'b0000;
    tick(2);
    chk("single_idle_busy", busy, 0);
    tick(1);
    chk("single_up", UpState, 1);
    chk("single_addr", state, 2);
    chk("single_busy1", busy, 1);
    tick(1);
    chk("single_up_drop", UpState, 0);
    chk("single_busy2", busy, 1);
    tick(1);
    chk("single_busy_end", busy, 0);
    tick(2);
    chk("single_up_count", count_up(2), 1);
    chk("single_up_cycle", first_up(2) - r, 37);

    // Two presses coincident with the ptr=0 decay wrap
    do_reset(r);
    tick(5);
    btn_up = 4'b1010;
    tick(1);
    btn_up = 4'b0000;
    tick(10);
    chk("simul_count", seen.size() >= 3, 1);
    if (seen.size() >= 3) begin
      chk("simul0_cyc", seen[0].cyc - r, 9);
      chk("simul0_ev", {seen[0].up, 3'(seen[0].addr)}, {1'b1, 3'd1});
      chk("simul1_cyc", seen[1].cyc - r, 12);
      chk("simul1_ev", {seen[1].up, 3'(seen[1].addr)}, {1'b1, 3'd3});
      chk("simul2_cyc", seen[2].cyc - r, 15);
      chk("simul2_ev", {seen[2].up, 3'(seen[2].addr)}, {1'b0, 3'd0});
    end

    // Double press of button 0 while busy with button 2
    do_reset(r);
    tick(1);
    btn_up = 4'b0100;
    tick(1);
    btn_up = 4'b0001;
    tick(1);
    btn_up = 4'b0000;
    tick(1);
    btn_up = 4'b0001;
    tick(1);
    btn_up = 4'b0000;
    tick(15);
    chk("merge_up2_cycle", first_up(2) - r, 5);
    chk("merge_up0_count", count_up(0), 1);
    chk("merge_up0_cycle", first_up(0) - r, 8);
    chk("merge_ovr", overrun, 1);
    tick(50);
    chk("merge_ovr_sticky", overrun, 1);
    do_reset(r);
    chk("merge_ovr_cleared", overrun, 0);

    // Reset asserted during ISSUE
    tick(1);
    btn_up = 4'b0010;
    tick(1);
    btn_up = 4'b1000;
    tick(1);
    btn_up = 4'b0000;
    tick(2);
    chk("abort_issue_up", UpState, 1);
    chk("abort_issue_addr", state, 1);
    rst = 1'b1;
    tick(1);
    chk("abort_up", UpState, 0);
    chk("abort_dn", DownState, 0);
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    seen.delete();
    tick(8);
    chk("abort_no_pulse", seen.size(), 0);

    // Button held through reset yields one request
    btn_up = 4'b0100;
    do_reset(r);
    tick(10);
    chk("held_up_count", count_up(2), 1);
    chk("held_up_cycle", first_up(2) - r, 4);
    btn_up = 4'b0000;
    tick(4);

    // Random button traffic, model and protocol checks run continuously
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      if ($urandom_range(0, 5) == 0) btn_up = 4'($urandom);
    end
    btn_up = 4'b0000;
    tick(30);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
